cache_dirty_tracker: RTL and testbench
======================================

// Module: cache_dirty_tracker
// PURPOSE
//  Per-set, per-way dirty-bit store for an N-way set-associative cache; successor to the
//  2-way dirty-load decode. Owns the dirty array, updates it from controller set/clear commands,
//  reports victim dirtiness for the writeback decision, and runs a flush engine that walks
//  all sets and hands out every dirty (set,way) over a valid/ready writeback handshake.
// PARAMETERS
//  NUM_WAYS  4  associativity; power of 2, >=2
//  NUM_SETS  8  number of sets; power of 2, >=2
//  WAY_W     $clog2(NUM_WAYS)  way index width (derived, do not override)
//  SET_W     $clog2(NUM_SETS)  set index width (derived, do not override)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  set_idx       in   SET_W  set addressed by the current access
//  hit_way       in   WAY_W  way that hit (target of set_dirty)
//  victim_way    in   WAY_W  replacement victim from the LRU logic (target of clr_dirty)
//  set_dirty     in   1      mark dirty[set_idx][hit_way]
//  clr_dirty     in   1      clear dirty[set_idx][victim_way] (line refilled)
//  victim_dirty  out  1      combinational dirty[set_idx][victim_way]
//  flush_req     in   1      level; start a flush when idle
//  flush_busy    out  1      high in any state other than IDLE
//  flush_done    out  1      one-cycle pulse when the flush completes
//  wb_valid      out  1      writeback request valid
//  wb_ready      in   1      writeback accepted by the memory side
//  wb_set        out  SET_W  set of the line to write back
//  wb_way        out  WAY_W  way of the line to write back
//  dirty_count   out  $clog2(NUM_SETS*NUM_WAYS+1)  present only with DIRTY_COUNT_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0): all dirty bits 0, FSM=IDLE, scan pointer 0; flush_busy=0,
//    flush_done=0, wb_valid=0, wb_set=0, wb_way=0, dirty_count=0. Reset mid-flush aborts it.
//  - Updates take effect at the next rising edge; victim_dirty reflects stored state (no bypass).
//  - set_dirty and clr_dirty in the same cycle: set_dirty wins; clr_dirty dropped, even when
//    hit_way != victim_way.
//  - While flush_busy=1, set_dirty/clr_dirty are ignored; the controller stalls on flush_busy.
//  - FSM: IDLE -> SCAN on flush_req (1 cycle later flush_busy=1, scan pointer=0).
//    SCAN: if set[ptr] has any dirty way, load wb_set=ptr, wb_way=lowest dirty way -> ISSUE;
//    else if ptr==NUM_SETS-1 -> DONE; else ptr+1 and stay in SCAN (1 cycle per clean set).
//    ISSUE: wb_valid=1; wb_set/wb_way held stable until wb_ready. On wb_valid&&wb_ready the
//    bit is cleared at that edge and the FSM returns to SCAN on the same ptr.
//    DONE: flush_done=1 for one cycle -> IDLE. flush_req still high in IDLE starts a new flush.
//  - All-clean cache: flush takes NUM_SETS SCAN cycles plus 1 DONE cycle, with no wb_valid.
//  - wb_valid never drops without a handshake, except on reset.
//  - Pointer wrap: ptr never increments past NUM_SETS-1; the last set exits to DONE.
// CONFIGURATION
//  DIRTY_COUNT_EN defined: dirty_count port and a population counter are present. The counter
//    does +1 on a 0->1 transition, -1 on a 1->0 transition (clr_dirty or flush handshake) and
//    stays unchanged for redundant set/clear commands. Saturation cannot occur by construction.
//  DIRTY_COUNT_EN undefined: no port and no counter logic; all other behaviour is identical.
// TESTING
//  1. Reset, then set_idx=3,hit_way=2,set_dirty=1 for 1 cycle; victim_way=2 -> victim_dirty=1
//     next cycle; clr_dirty with victim_way=2 -> victim_dirty=0.
//  2. set_dirty(hit_way=1) and clr_dirty(victim_way=1) in the same cycle on set 5 ->
//     dirty[5][1]=1.
//  3. Dirty (0,3),(0,1),(6,0); pulse flush_req, wb_ready=1 -> wb order (0,1),(0,3),(6,0);
//     flush_done pulses once; array all clean.
//  4. Clean cache, flush_req -> flush_busy high for NUM_SETS+1=9 cycles, wb_valid never high,
//     one flush_done pulse.
//  5. Flush with wb_ready=0 for 5 cycles -> wb_valid/wb_set/wb_way stable; set_dirty issued
//     during busy has no effect.
//  6. Assert rst_n=0 while in ISSUE -> wb_valid=0 and flush_busy=0 immediately, array clear;
//     with DIRTY_COUNT_EN, 3 distinct set_dirty then 1 clr_dirty -> dirty_count=2.

Source files
------------

// File: rtl/cache_dirty_tracker.sv
// rtl/cache_dirty_tracker.sv - per-set/per-way dirty store with a flush/writeback engine
// Optional population counter on dirty_count is built when DIRTY_COUNT_EN is defined.
module cache_dirty_tracker #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 8,
   localparam int WAY_W = $clog2(NUM_WAYS),
   localparam int SET_W = $clog2(NUM_SETS)
`ifdef DIRTY_COUNT_EN
   ,localparam int CNT_W = $clog2(NUM_SETS*NUM_WAYS+1)
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SET_W-1:0] set_idx,
   input  logic [WAY_W-1:0] hit_way,
   input  logic [WAY_W-1:0] victim_way,
   input  logic             set_dirty,
   input  logic             clr_dirty,
   output logic             victim_dirty,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic             flush_done,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [SET_W-1:0] wb_set,
   output logic [WAY_W-1:0] wb_way
`ifdef DIRTY_COUNT_EN
   ,output logic [CNT_W-1:0] dirty_count
`endif
);

   typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

   state_t              state, state_nxt;
   logic [NUM_WAYS-1:0] dirty [NUM_SETS];
   logic [SET_W-1:0]    ptr;
   logic [WAY_W-1:0]    low_way;
   logic                row_dirty;
   logic                cmd_en;
   logic                wb_fire;

   assign cmd_en       = (state == IDLE);
   assign wb_fire      = (state == ISSUE) && wb_ready;
   assign victim_dirty = dirty[set_idx][victim_way];

   // Descending walk so the last hit left standing is the lowest dirty way.
   always_comb begin
      row_dirty = |dirty[ptr];
      low_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (dirty[ptr][w]) low_way = WAY_W'(w);
      end
   end

   always_comb begin
      state_nxt  = state;
      flush_busy = (state != IDLE);
      flush_done = 1'b0;
      wb_valid   = 1'b0;
      case (state)
         IDLE:  if (flush_req) state_nxt = SCAN;
         SCAN: begin
            if (row_dirty)             state_nxt = ISSUE;
            else if (ptr == LAST_SET)  state_nxt = DONE;
         end
         ISSUE: begin
            wb_valid = 1'b1;
            if (wb_ready) state_nxt = SCAN;
         end
         DONE: begin
            flush_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         wb_set <= '0;
         wb_way <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (flush_req) ptr <= '0;
            SCAN: begin
               if (row_dirty) begin
                  wb_set <= ptr;
                  wb_way <= low_way;
               end else if (ptr != LAST_SET) begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Commands are only honoured while idle; set wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) dirty[s] <= '0;
      end else if (wb_fire) begin
         dirty[wb_set][wb_way] <= 1'b0;
      end else if (cmd_en) begin
         if (set_dirty)      dirty[set_idx][hit_way]    <= 1'b1;
         else if (clr_dirty) dirty[set_idx][victim_way] <= 1'b0;
      end
   end

`ifdef DIRTY_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty_count <= '0;
      end else if (wb_fire) begin
         dirty_count <= dirty_count - CNT_W'(1);
      end else if (cmd_en) begin
         if (set_dirty && !dirty[set_idx][hit_way])
            dirty_count <= dirty_count + CNT_W'(1);
         else if (!set_dirty && clr_dirty && victim_dirty)
            dirty_count <= dirty_count - CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cache_dirty_tracker.sv
// tb/tb_cache_dirty_tracker.sv - self-checking bench for cache_dirty_tracker against a set/way array model
module tb_cache_dirty_tracker;

   localparam int NW = 4;
   localparam int NS = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] set_idx = '0;
   logic [1:0] hit_way = '0;
   logic [1:0] victim_way = '0;
   logic       set_dirty = 1'b0;
   logic       clr_dirty = 1'b0;
   logic       victim_dirty;
   logic       flush_req = 1'b0;
   logic       flush_busy;
   logic       flush_done;
   logic       wb_valid;
   logic       wb_ready = 1'b0;
   logic [2:0] wb_set;
   logic [1:0] wb_way;
`ifdef DIRTY_COUNT_EN
   logic [5:0] dirty_count;
`endif

   int checks = 0;
   int errors = 0;
   bit mdl [NS][NW];
   int bc;

   cache_dirty_tracker #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
      .clk(clk), .rst_n(rst_n), .set_idx(set_idx), .hit_way(hit_way),
      .victim_way(victim_way), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
      .victim_dirty(victim_dirty), .flush_req(flush_req), .flush_busy(flush_busy),
      .flush_done(flush_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_set(wb_set), .wb_way(wb_way)
`ifdef DIRTY_COUNT_EN
      , .dirty_count(dirty_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int popcount();
      int n = 0;
      foreach (mdl[s, w]) n += int'(mdl[s][w]);
      return n;
   endfunction

   task automatic chk_count(input string tag);
`ifdef DIRTY_COUNT_EN
      chk(tag, 32'(dirty_count), 32'(popcount()));
`endif
   endtask

   task automatic clear_model();
      foreach (mdl[s, w]) mdl[s][w] = 1'b0;
   endtask

   // One idle-time command; the model applies the same rules after the edge.
   task automatic cmd(input int s, input int h, input int v, input bit sd, input bit cd);
      set_idx = 3'(s); hit_way = 2'(h); victim_way = 2'(v);
      set_dirty = sd; clr_dirty = cd;
      tick();
      set_dirty = 1'b0; clr_dirty = 1'b0;
      if (sd) mdl[s][h] = 1'b1;
      else if (cd) mdl[s][v] = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] got = '0;
      logic [31:0] exp = '0;
      for (int s = 0; s < NS; s++) begin
         for (int w = 0; w < NW; w++) begin
            set_idx = 3'(s); victim_way = 2'(w);
            tick();
            got[s*NW+w] = victim_dirty;
            exp[s*NW+w] = mdl[s][w];
         end
      end
      chk(tag, got, exp);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 50; i++) begin
         if (wb_valid) break;
         tick();
      end
      chk(tag, 32'(wb_valid), 32'd1);
   endtask

   // Runs one full flush; the expected writeback order is every dirty line, sets ascending, ways ascending.
   task automatic run_flush(input bit rnd, input bit poke, output int busy_cycles);
      int exp_q[$];
      int dones = 0;
      int vcnt = 0;
      int hs = 0;
      bit pv = 1'b0, phs = 1'b0, fin = 1'b0;
      logic [2:0] ps = '0;
      logic [1:0] pw = '0;
      bit was_clean;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            if (mdl[s][w]) exp_q.push_back(s*NW + w);
      was_clean = (exp_q.size() == 0);
      busy_cycles = 0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (flush_busy) busy_cycles++;
         if (wb_valid) vcnt++;
         if (pv && !phs) begin
            chk("wb_hold_valid", 32'(wb_valid), 32'd1);
            chk("wb_hold_line", {27'd0, wb_set, wb_way}, {27'd0, ps, pw});
         end
         if (flush_done) begin
            dones++;
            fin = 1'b1;
            wb_ready = 1'b0;
            set_dirty = 1'b0;
            break;
         end
         wb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke) begin
            set_idx = 3'($urandom_range(0, NS-1));
            hit_way = 2'($urandom_range(0, NW-1));
            victim_way = 2'($urandom_range(0, NW-1));
            set_dirty = 1'($urandom_range(0, 1));
            clr_dirty = 1'($urandom_range(0, 1));
         end
         if (wb_valid && wb_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
               chk("wb_unexpected", {27'd0, wb_set, wb_way}, 32'hFFFF_FFFF);
            end else begin
               chk("wb_order", {27'd0, wb_set, wb_way}, 32'(exp_q.pop_front()));
               mdl[wb_set][wb_way] = 1'b0;
            end
         end
         pv = wb_valid; phs = wb_valid && wb_ready; ps = wb_set; pw = wb_way;
         tick();
      end
      set_dirty = 1'b0; clr_dirty = 1'b0; wb_ready = 1'b0;
      chk("flush_finished", 32'(fin), 32'd1);
      chk("wb_all_issued", 32'(exp_q.size()), 32'd0);
      if (was_clean) chk("clean_no_wb_valid", 32'(vcnt), 32'd0);
      tick();
      chk("done_one_pulse", 32'(flush_done), 32'd0);
      chk("done_count", 32'(dones), 32'd1);
      chk("idle_after_flush", 32'(flush_busy), 32'd0);
      chk_count("count_after_flush");
   endtask

   initial begin
      clear_model();
      tick();
      chk("rst_busy", 32'(flush_busy), 32'd0);
      chk("rst_done", 32'(flush_done), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_line", {27'd0, wb_set, wb_way}, 32'd0);
      chk_count("rst_count");
      rst_n = 1'b1;
      check_all("rst_array");

      // Single set then clear through victim_way.
      cmd(3, 2, 2, 1'b1, 1'b0);
      set_idx = 3'd3; victim_way = 2'd2; #1;
      chk("t1_set_visible", 32'(victim_dirty), 32'd1);
      cmd(3, 0, 2, 1'b0, 1'b1);
      set_idx = 3'd3; victim_way = 2'd2; #1;
      chk("t1_clr_visible", 32'(victim_dirty), 32'd0);

      // Simultaneous set/clear: set wins, clear dropped even on another way.
      cmd(5, 1, 1, 1'b1, 1'b1);
      set_idx = 3'd5; victim_way = 2'd1; #1;
      chk("t2_set_wins_same", 32'(victim_dirty), 32'd1);
      cmd(5, 3, 1, 1'b1, 1'b1);
      set_idx = 3'd5; victim_way = 2'd1; #1;
      chk("t2_clr_dropped", 32'(victim_dirty), 32'd1);
      chk_count("t2_count");

      // Random command traffic, victim_dirty compared before every edge.
      for (int i = 0; i < 200; i++) begin
         set_idx = 3'($urandom_range(0, NS-1));
         hit_way = 2'($urandom_range(0, NW-1));
         victim_way = 2'($urandom_range(0, NW-1));
         set_dirty = ($urandom_range(0, 2) == 0);
         clr_dirty = ($urandom_range(0, 2) == 0);
         #1;
         chk("rnd_victim", 32'(victim_dirty), 32'(mdl[set_idx][victim_way]));
         tick();
         if (set_dirty) mdl[set_idx][hit_way] = 1'b1;
         else if (clr_dirty) mdl[set_idx][victim_way] = 1'b0;
         set_dirty = 1'b0; clr_dirty = 1'b0;
         chk_count("rnd_count");
      end

      run_flush(1'b1, 1'b1, bc);
      check_all("rnd_flush_clean");

      // Directed writeback order.
      cmd(0, 3, 0, 1'b1, 1'b0);
      cmd(0, 1, 0, 1'b1, 1'b0);
      cmd(6, 0, 0, 1'b1, 1'b0);
      run_flush(1'b0, 1'b0, bc);
      check_all("t3_array_clean");

      // Clean cache: NUM_SETS scan cycles plus one done cycle.
      run_flush(1'b0, 1'b0, bc);
      chk("t4_busy_cycles", 32'(bc), 32'(NS + 1));

      // Stall in ISSUE with commands ignored.
      cmd(2, 2, 0, 1'b1, 1'b0);
      flush_req = 1'b1; wb_ready = 1'b0;
      tick();
      flush_req = 1'b0;
      wait_valid("t5_wait_valid");
      chk("t5_line", {27'd0, wb_set, wb_way}, {27'd0, 3'd2, 2'd2});
      for (int i = 0; i < 5; i++) begin
         set_idx = 3'd4; hit_way = 2'd1; set_dirty = 1'b1;
         tick();
         chk("t5_stall_valid", 32'(wb_valid), 32'd1);
         chk("t5_stall_line", {27'd0, wb_set, wb_way}, {27'd0, 3'd2, 2'd2});
      end
      set_dirty = 1'b0; wb_ready = 1'b1;
      tick();
      mdl[2][2] = 1'b0;
      wb_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (!flush_busy) break;
         tick();
      end
      chk("t5_finished", 32'(flush_busy), 32'd0);
      check_all("t5_array");

      // Reset while a writeback is pending.
      cmd(7, 3, 0, 1'b1, 1'b0);
      cmd(1, 2, 0, 1'b1, 1'b0);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      wait_valid("t6_wait_valid");
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("t6_rst_busy", 32'(flush_busy), 32'd0);
      tick();
      rst_n = 1'b1;
      clear_model();
      check_all("t6_array_clear");
      cmd(1, 0, 0, 1'b1, 1'b0);
      cmd(2, 1, 0, 1'b1, 1'b0);
      cmd(3, 2, 0, 1'b1, 1'b0);
      cmd(2, 0, 1, 1'b0, 1'b1);
      chk("t6_pop_model", 32'(popcount()), 32'd2);
      chk_count("t6_count");
      cmd(3, 0, 2, 1'b0, 1'b1);
      cmd(3, 0, 2, 1'b0, 1'b1);
      cmd(1, 0, 0, 1'b1, 1'b0);
      chk_count("t6_redundant_count");
      check_all("t6_final_array");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
